branch_resolve_queue: RTL and testbench

- In-order queue between fetch-side gshare prediction and execute-side branch resolution.
- Each accepted prediction pushes {pc, predicted direction, GHR snapshot}.
- Each resolution pops the head, drives the predictor's train interface (train_valid/train_pc/train_taken) and detects mispredicts.
- On a mispredict it flushes all younger entries and outputs the corrected history for recovery.

---
 rtl/branch_resolve_queue.sv | 124 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-order queue of gshare predictions awaiting resolution. It pops on resolve, trains the
// predictor, and flushes younger entries plus emits recovery history on a mispredict.
module branch_resolve_queue #(
    parameter int unsigned PC_W   = 7,
    parameter int unsigned HIST_W = 7,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [PC_W-1:0]   push_pc,
    input  logic              push_taken,
    input  logic [HIST_W-1:0] push_history,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic              train_valid,
    output logic [PC_W-1:0]   train_pc,
    output logic              train_taken,
    output logic              mispredict,
    output logic [HIST_W-1:0] recover_history,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              underflow_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [HIST_W-1:0] hist_mem [DEPTH];
    logic [DEPTH-1:0]  taken_mem;

    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              train_valid_q;
    logic [PC_W-1:0]   train_pc_q;
    logic              train_taken_q;
    logic              mispredict_q;
    logic [HIST_W-1:0] recover_history_q;
    logic              underflow_q;

    logic push_fire;
    logic pop_fire;
    logic mis;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign push_ready = !full;
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = resolve_valid && !empty;
    assign mis        = pop_fire && (taken_mem[rd_ptr_q] != resolve_taken);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (mis) begin
            // Fetch is being redirected: drop every younger entry and any same-cycle push.
            rd_ptr_d = rd_ptr_q + AW'(1);
            wr_ptr_d = rd_ptr_q + AW'(1);
            count_d  = '0;
        end else begin
            if (push_fire) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (!rst && push_fire && !mis) begin
            pc_mem[wr_ptr_q]    <= push_pc;
            hist_mem[wr_ptr_q]  <= push_history;
            taken_mem[wr_ptr_q] <= push_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q          <= '0;
            wr_ptr_q          <= '0;
            count_q           <= '0;
            train_valid_q     <= 1'b0;
            train_pc_q        <= '0;
            train_taken_q     <= 1'b0;
            mispredict_q      <= 1'b0;
            recover_history_q <= '0;
            underflow_q       <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            train_valid_q <= pop_fire;
            mispredict_q  <= mis;
            underflow_q   <= underflow_q || (resolve_valid && empty);
            if (pop_fire) begin
                train_pc_q        <= pc_mem[rd_ptr_q];
                train_taken_q     <= resolve_taken;
                recover_history_q <= {hist_mem[rd_ptr_q][HIST_W-2:0], resolve_taken};
            end
        end
    end

    assign train_valid     = train_valid_q;
    assign train_pc        = train_pc_q;
    assign train_taken     = train_taken_q;
    assign mispredict      = mispredict_q;
    assign recover_history = recover_history_q;
    assign count           = count_q;
    assign underflow_err   = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: in-order training, mispredict flush, full/wrap,
// steady-state push+pop, underflow, and mid-stream reset.
module tb_branch_resolve_queue;

    localparam int unsigned PC_W   = 7;
    localparam int unsigned HIST_W = 7;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              push_valid;
    logic              push_ready;
    logic [PC_W-1:0]   push_pc;
    logic              push_taken;
    logic [HIST_W-1:0] push_history;
    logic              resolve_valid;
    logic              resolve_taken;
    logic              train_valid;
    logic [PC_W-1:0]   train_pc;
    logic              train_taken;
    logic              mispredict;
    logic [HIST_W-1:0] recover_history;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              underflow_err;

    int checks   = 0;
    int failures = 0;

    branch_resolve_queue #(
        .PC_W   (PC_W),
        .HIST_W (HIST_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .push_valid      (push_valid),
        .push_ready      (push_ready),
        .push_pc         (push_pc),
        .push_taken      (push_taken),
        .push_history    (push_history),
        .resolve_valid   (resolve_valid),
        .resolve_taken   (resolve_taken),
        .train_valid     (train_valid),
        .train_pc        (train_pc),
        .train_taken     (train_taken),
        .mispredict      (mispredict),
        .recover_history (recover_history),
        .count           (count),
        .empty           (empty),
        .full            (full),
        .underflow_err   (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge.
    task automatic step(input logic pv, input logic [PC_W-1:0] pc, input logic pt,
                        input logic [HIST_W-1:0] ph, input logic rv, input logic rt);
        push_valid    = pv;
        push_pc       = pc;
        push_taken    = pt;
        push_history  = ph;
        resolve_valid = rv;
        resolve_taken = rt;
        @(posedge clk);
        #1;
        push_valid    = 1'b0;
        resolve_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        push_valid = 1'b0; push_pc = '0; push_taken = 1'b0; push_history = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ready", 32'(push_ready), 1);
        chk("rst_train_valid", 32'(train_valid), 0);
        chk("rst_mispredict", 32'(mispredict), 0);
        chk("rst_underflow", 32'(underflow_err), 0);

        // Three pushes, three correct resolves
        step(1, 7'h05, 1, 7'h00, 0, 0); chk("p1_count", 32'(count), 1);
        step(1, 7'h12, 0, 7'h01, 0, 0); chk("p2_count", 32'(count), 2);
        step(1, 7'h33, 1, 7'h02, 0, 0); chk("p3_count", 32'(count), 3);
        chk("p3_no_train", 32'(train_valid), 0);
        step(0, 0, 0, 0, 1, 1);
        chk("r1_tv", 32'(train_valid), 1); chk("r1_pc", 32'(train_pc), 32'h05);
        chk("r1_tk", 32'(train_taken), 1); chk("r1_mis", 32'(mispredict), 0);
        chk("r1_count", 32'(count), 2);
        step(0, 0, 0, 0, 1, 0);
        chk("r2_tv", 32'(train_valid), 1); chk("r2_pc", 32'(train_pc), 32'h12);
        chk("r2_tk", 32'(train_taken), 0); chk("r2_mis", 32'(mispredict), 0);
        chk("r2_count", 32'(count), 1);
        step(0, 0, 0, 0, 1, 1);
        chk("r3_tv", 32'(train_valid), 1); chk("r3_pc", 32'(train_pc), 32'h33);
        chk("r3_tk", 32'(train_taken), 1); chk("r3_mis", 32'(mispredict), 0);
        chk("r3_count", 32'(count), 0); chk("r3_empty", 32'(empty), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("idle_tv", 32'(train_valid), 0); chk("idle_pc_hold", 32'(train_pc), 32'h33);

        // Mispredict flush: predicted NT, actual T; history 0x2A -> 0x55
        step(1, 7'h10, 0, 7'h2A, 0, 0);
        step(1, 7'h11, 1, 7'h15, 0, 0);
        chk("m_count_pre", 32'(count), 2);
        step(0, 0, 0, 0, 1, 1);
        chk("m_mis", 32'(mispredict), 1); chk("m_hist", 32'(recover_history), 32'h55);
        chk("m_pc", 32'(train_pc), 32'h10); chk("m_tk", 32'(train_taken), 1);
        chk("m_tv", 32'(train_valid), 1);
        chk("m_count", 32'(count), 0); chk("m_empty", 32'(empty), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("m_mis_pulse", 32'(mispredict), 0);

        // Fill to full across the pointer wrap; 9th push ignored
        for (int i = 0; i < 8; i++) begin
            step(1, 7'(8'h20 + i), i[0], 7'(i), 0, 0);
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        chk("full_flag", 32'(full), 1); chk("full_ready", 32'(push_ready), 0);
        step(1, 7'h7F, 0, 7'h00, 0, 0);
        chk("ovf_count", 32'(count), 8); chk("ovf_full", 32'(full), 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 1, i[0]);
            chk("drain_pc", 32'(train_pc), 32'(8'h20 + i));
            chk("drain_mis", 32'(mispredict), 0);
            chk("drain_count", 32'(count), 32'(7 - i));
        end
        chk("drain_empty", 32'(empty), 1);

        // Steady state: push and correct pop each cycle at count 4
        for (int i = 0; i < 4; i++) step(1, 7'(8'h40 + i), 1, 7'(i), 0, 0);
        chk("ss_count_pre", 32'(count), 4);
        for (int i = 0; i < 5; i++) begin
            step(1, 7'(8'h44 + i), 1, 7'(i), 1, 1);
            chk("ss_pc", 32'(train_pc), 32'(8'h40 + i));
            chk("ss_count", 32'(count), 4);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 1);
            chk("ss_drain_pc", 32'(train_pc), 32'(8'h45 + i));
        end
        chk("ss_empty", 32'(empty), 1);

        // Resolve while empty
        step(0, 0, 0, 0, 1, 1);
        chk("uf_flag", 32'(underflow_err), 1); chk("uf_tv", 32'(train_valid), 0);
        chk("uf_count", 32'(count), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("uf_sticky", 32'(underflow_err), 1);

        // Reset mid-stream with a resolve in flight
        for (int i = 0; i < 5; i++) step(1, 7'(8'h50 + i), 0, 7'(i), 0, 0);
        chk("rs_count_pre", 32'(count), 5);
        step(0, 0, 0, 0, 1, 0);
        chk("rs_tv_pre", 32'(train_valid), 1); chk("rs_pc_pre", 32'(train_pc), 32'h50);
        rst = 1'b1;
        step(0, 0, 0, 0, 1, 1);
        rst = 1'b0;
        chk("rs_count", 32'(count), 0); chk("rs_empty", 32'(empty), 1);
        chk("rs_tv", 32'(train_valid), 0); chk("rs_mis", 32'(mispredict), 0);
        chk("rs_underflow", 32'(underflow_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
